// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with wait-state timeout
//
// Ports:
//   pclk, presetn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (accept on valid & ready)
//   cmd_write/addr/wdata/prot     command payload, registered onto the APB bus
//   rsp_valid                     one-cycle completion strobe
//   rsp_rdata/err/timeout         completion status (rdata is 0 for writes/timeouts)
//   psel/penable/pwrite/paddr/pwdata/pprot   APB requester outputs
//   pready/pslverr/prdata         APB completer inputs
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [2:0]            cmd_prot,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    // A zero TIMEOUT still gets a 1-bit counter so the logic stays legal;
    // the compare is masked off by to_en in that case.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic to_en = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t         state;
    logic [CW-1:0]  wait_cnt;
    logic           done;
    logic           to_hit;
    logic           accept;

    assign done   = (state == S_ACCESS) && pready;
    assign to_hit = to_en && (state == S_ACCESS) && !pready && (wait_cnt == TO_LAST);

    // Ready during the finishing ACCESS cycle lets the next command go
    // straight to SETUP, keeping psel high across back-to-back transfers.
    assign cmd_ready = (state == S_IDLE) || done || to_hit;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pprot       <= 3'b000;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // Response fields are a one-cycle strobe; cleared unless set below.
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            // Bus payload only moves on accept and is otherwise held,
            // including in IDLE.
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pprot  <= cmd_prot;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_SETUP;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                    end
                end

                S_SETUP: begin
                    state   <= S_ACCESS;
                    penable <= 1'b1;
                end

                S_ACCESS: begin
                    if (done || to_hit) begin
                        rsp_valid <= 1'b1;
                        if (done) begin
                            rsp_err   <= pslverr;
                            rsp_rdata <= pwrite ? '0 : prdata;
                        end else begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                        if (accept) begin
                            state    <= S_SETUP;
                            psel     <= 1'b1;
                            penable  <= 1'b0;
                            wait_cnt <= '0;
                        end else begin
                            state   <= S_IDLE;
                            psel    <= 1'b0;
                            penable <= 1'b0;
                        end
                    end else if (wait_cnt != {CW{1'b1}}) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int n_cmp = 0;
    int n_err = 0;
    int pen_cnt;

    apb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_prot   (cmd_prot),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pprot      (pprot),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick;
        @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_prot  = p;
    endtask

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_prot  = 3'b000;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;

        // Reset state
        tick; tick;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwrite", pwrite, 1'b0);
        presetn = 1'b1;
        tick;

        // 1: zero-wait write 0xDEADBEEF to 0x4
        send(1'b1, 32'h4, 32'hDEADBEEF, 3'b010);
        pready = 1'b1;
        chk("w1_ready_idle", cmd_ready, 1'b1);
        tick;                                   // after E0: SETUP
        cmd_valid = 1'b0;
        chk("w1_setup_psel", psel, 1'b1);
        chk("w1_setup_pen", penable, 1'b0);
        chk("w1_pwrite", pwrite, 1'b1);
        chk("w1_paddr", paddr, 32'h4);
        chk("w1_pwdata", pwdata, 32'hDEADBEEF);
        chk("w1_pprot", pprot, 3'b010);
        chk("w1_setup_ready", cmd_ready, 1'b0);
        tick;                                   // after E1: ACCESS
        chk("w1_acc_psel", psel, 1'b1);
        chk("w1_acc_pen", penable, 1'b1);
        chk("w1_acc_rspv", rsp_valid, 1'b0);
        tick;                                   // after E2: response
        chk("w1_rspv", rsp_valid, 1'b1);
        chk("w1_err", rsp_err, 1'b0);
        chk("w1_to", rsp_timeout, 1'b0);
        chk("w1_rdata", rsp_rdata, 32'h0);
        chk("w1_idle_psel", psel, 1'b0);
        chk("w1_idle_pen", penable, 1'b0);
        chk("w1_idle_paddr_hold", paddr, 32'h4);
        tick;
        chk("w1_rspv_pulse", rsp_valid, 1'b0);

        // 2: read 0x4 with three wait states
        send(1'b0, 32'h4, 32'h0, 3'b000);
        pready = 1'b0;
        prdata = 32'h12345678;
        tick;                                   // SETUP
        cmd_valid = 1'b0;
        chk("r2_setup_pen", penable, 1'b0);
        pen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (penable === 1'b1) pen_cnt++;
            chk("r2_wait_paddr", paddr, 32'h4);
            chk("r2_wait_rspv", rsp_valid, 1'b0);
        end
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
        tick;                                   // 5 edges after accept
        chk("r2_pen_cycles", pen_cnt, 4);
        chk("r2_rspv", rsp_valid, 1'b1);
        chk("r2_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("r2_err", rsp_err, 1'b0);
        chk("r2_psel", psel, 1'b0);

        // 3: back-to-back write 0x8 then read 0x8
        send(1'b1, 32'h8, 32'hA5A5A5A5, 3'b000);
        prdata = 32'h0BADF00D;
        tick;                                   // SETUP (write)
        send(1'b0, 32'h8, 32'h0, 3'b001);
        chk("b3_setup_ready", cmd_ready, 1'b0);
        tick;                                   // ACCESS (write)
        chk("b3_acc1_pen", penable, 1'b1);
        chk("b3_acc1_ready", cmd_ready, 1'b1);
        chk("b3_acc1_pwrite", pwrite, 1'b1);
        tick;                                   // rsp #1, SETUP (read)
        cmd_valid = 1'b0;
        chk("b3_rsp1", rsp_valid, 1'b1);
        chk("b3_rsp1_rdata", rsp_rdata, 32'h0);
        chk("b3_gap_psel", psel, 1'b1);
        chk("b3_gap_pen", penable, 1'b0);
        chk("b3_gap_pwrite", pwrite, 1'b0);
        chk("b3_gap_pprot", pprot, 3'b001);
        tick;                                   // ACCESS (read)
        chk("b3_acc2_psel", psel, 1'b1);
        chk("b3_acc2_pen", penable, 1'b1);
        chk("b3_acc2_rspv", rsp_valid, 1'b0);
        tick;                                   // rsp #2
        chk("b3_rsp2", rsp_valid, 1'b1);
        chk("b3_rsp2_rdata", rsp_rdata, 32'h0BADF00D);
        chk("b3_end_psel", psel, 1'b0);

        // 4: read 0x40 with pslverr
        send(1'b0, 32'h40, 32'h0, 3'b000);
        prdata  = 32'h40404040;
        pslverr = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        chk("e4_rspv", rsp_valid, 1'b1);
        chk("e4_err", rsp_err, 1'b1);
        chk("e4_to", rsp_timeout, 1'b0);
        chk("e4_rdata", rsp_rdata, 32'h40404040);
        pslverr = 1'b0;
        tick;

        // 5: timeout with pready held low (TIMEOUT = 4)
        send(1'b0, 32'h10, 32'h0, 3'b000);
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        tick;                                   // SETUP
        cmd_valid = 1'b0;
        tick;                                   // ACCESS, cnt 0
        chk("t5_acc_ready", cmd_ready, 1'b0);
        tick; tick; tick;                       // cnt 3: abort armed
        chk("t5_last_pen", penable, 1'b1);
        chk("t5_last_rspv", rsp_valid, 1'b0);
        chk("t5_last_ready", cmd_ready, 1'b1);
        tick;                                   // N+1 = 5 edges after accept
        chk("t5_rspv", rsp_valid, 1'b1);
        chk("t5_err", rsp_err, 1'b1);
        chk("t5_to", rsp_timeout, 1'b1);
        chk("t5_rdata", rsp_rdata, 32'h0);
        chk("t5_psel", psel, 1'b0);
        chk("t5_ready", cmd_ready, 1'b1);
        tick;
        chk("t5_rspv_pulse", rsp_valid, 1'b0);

        // 6: reset during ACCESS, then a normal write
        send(1'b1, 32'h20, 32'h55555555, 3'b000);
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("r6_acc_pen", penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        chk("r6_async_psel", psel, 1'b0);
        chk("r6_async_pen", penable, 1'b0);
        pready = 1'b1;
        tick;
        chk("r6_no_rsp_a", rsp_valid, 1'b0);
        tick;
        chk("r6_no_rsp_b", rsp_valid, 1'b0);
        presetn = 1'b1;
        tick;
        chk("r6_no_rsp_c", rsp_valid, 1'b0);
        send(1'b1, 32'h24, 32'h11223344, 3'b000);
        tick;
        cmd_valid = 1'b0;
        chk("r6_paddr", paddr, 32'h24);
        tick;
        chk("r6_acc_pen2", penable, 1'b1);
        tick;
        chk("r6_rspv", rsp_valid, 1'b1);
        chk("r6_err", rsp_err, 1'b0);
        chk("r6_pwdata", pwdata, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
